// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared bus widths and constant words for the IF/ID queue
package if_id_queue_pkg;

    localparam int INST_ADDR_BUS = 32;
    localparam int INST_BUS      = 32;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - in-order storage for fetched pc/inst pairs
module inst_fifo #(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = 64,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID instruction queue with registered decode stage and empty-queue bypass
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int  ADDR_W = INST_ADDR_BUS,
    parameter int  INST_W = INST_BUS,
    parameter int  DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    input  logic              id_stall,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [PTR_W:0]    count
);

    logic              fifo_full;
    logic              fifo_empty;
    logic              push_req;
    logic              bypass;
    logic              fifo_pop;
    logic              fifo_push;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;

    // if_ready comes from registered state only, so a same-cycle pop never frees a slot.
    assign if_ready  = ~fifo_full;
    assign push_req  = if_valid & if_ready;
    assign fifo_pop  = ~id_stall & ~fifo_empty;
    assign bypass    = ~id_stall & fifo_empty & push_req;
    assign fifo_push = push_req & ~bypass;

    inst_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ADDR_W + INST_W)
    ) u_inst_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (flush),
        .push      (fifo_push),
        .push_data ({if_pc, if_inst}),
        .pop       (fifo_pop),
        .head_data ({head_pc, head_inst}),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid <= 1'b0;
            id_pc    <= ADDR_W'(ZERO_WORD);
            id_inst  <= INST_W'(ZERO_WORD);
        end else if (flush) begin
            id_valid <= 1'b0;
            id_pc    <= ADDR_W'(ZERO_WORD);
            id_inst  <= INST_W'(NOP_INST);
        end else if (!id_stall) begin
            if (!fifo_empty) begin
                id_valid <= 1'b1;
                id_pc    <= head_pc;
                id_inst  <= head_inst;
            end else if (push_req) begin
                id_valid <= 1'b1;
                id_pc    <= if_pc;
                id_inst  <= if_inst;
            end else begin
                id_valid <= 1'b0;
                id_pc    <= ADDR_W'(ZERO_WORD);
                id_inst  <= INST_W'(NOP_INST);
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue-based reference model
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        id_stall = 1'b0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] m_q [$];
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_inst = '0;

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_stall (id_stall),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_pc    = '0;
        m_inst  = '0;
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic cycle();
        bit push;
        @(posedge clk);
        push = if_valid && (m_q.size() < DEPTH);
        if (flush) begin
            model_reset();
        end else begin
            if (!id_stall) begin
                if (m_q.size() > 0) begin
                    {m_pc, m_inst} = m_q.pop_front();
                    m_valid = 1'b1;
                end else if (push) begin
                    m_pc = if_pc;
                    m_inst = if_inst;
                    m_valid = 1'b1;
                    push = 1'b0;
                end else begin
                    m_valid = 1'b0;
                    m_pc = '0;
                    m_inst = '0;
                end
            end
            if (push) m_q.push_back({if_pc, if_inst});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_cmp++;
        if ({id_valid, id_pc, id_inst, count, if_ready} !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%0b pc=%h inst=%h cnt=%0d rdy=%0b want 0/0/0/0/1",
                     id_valid, id_pc, id_inst, count, if_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({id_valid, id_inst, count, if_ready} !== {1'b0, 32'h0, 3'd0, 1'b1}) begin
                n_err++;
                $display("FAIL idle_%0d: got v=%0b inst=%h cnt=%0d rdy=%0b want 0/0/0/1",
                         i, id_valid, id_inst, count, if_ready);
            end
        end
    endtask

    task automatic test_bypass(input string tag);
        id_stall = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h0001_0000;
        if_inst  = 32'h0000_0080;
        cycle();
        if_valid = 1'b0;
        n_cmp++;
        if ({id_valid, id_pc, id_inst, count} !== {1'b1, 32'h0001_0000, 32'h0000_0080, 3'd0}) begin
            n_err++;
            $display("FAIL %s: got v=%0b pc=%h inst=%h cnt=%0d want 1/00010000/00000080/0",
                     tag, id_valid, id_pc, id_inst, count);
        end
    endtask

    task automatic test_stall_fill();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h10, 32'h14, 32'h18, 32'h1C};
        id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_valid = 1'b1;
            if_pc    = 32'h10 + 32'(4 * i);
            if_inst  = 32'hA000_0000 + 32'(i);
            cycle();
        end
        if_valid = 1'b0;
        n_cmp++;
        if ({count, if_ready} !== {3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL fill_full: got cnt=%0d rdy=%0b want 4/0", count, if_ready);
        end
        n_cmp++;
        if ({id_valid, id_pc} !== {1'b1, 32'h0001_0000}) begin
            n_err++;
            $display("FAIL fill_hold: got v=%0b pc=%h want 1/00010000", id_valid, id_pc);
        end
        id_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++;
            if ({id_valid, id_pc, count} !== {1'b1, exp_pc[i], 3'(3 - i)}) begin
                n_err++;
                $display("FAIL drain_%0d: got v=%0b pc=%h cnt=%0d want 1/%h/%0d",
                         i, id_valid, id_pc, count, exp_pc[i], 3 - i);
            end
        end
        cycle();
        n_cmp++;
        if ({id_valid, id_pc, id_inst, count} !== {1'b0, 32'h0, 32'h0, 3'd0}) begin
            n_err++;
            $display("FAIL drain_bubble: got v=%0b pc=%h inst=%h cnt=%0d want 0/0/0/0",
                     id_valid, id_pc, id_inst, count);
        end
    endtask

    task automatic test_random_wrap();
        logic [31:0] sent [$];
        logic [31:0] got [$];
        logic [31:0] next_pc;
        int          errs;
        bit          acc;
        next_pc = 32'h0000_1000;
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            id_stall = ($urandom_range(0, 2) == 0);
            if_pc    = next_pc;
            if_inst  = $urandom;
            acc = if_valid && (m_q.size() < DEPTH);
            if (acc) sent.push_back(if_pc);
            cycle();
            if (acc) next_pc = next_pc + 32'd4;
            if (!id_stall && id_valid) got.push_back(id_pc);
            if ({id_valid, id_pc, id_inst, count, if_ready} !==
                {m_valid, m_pc, m_inst, 3'(m_q.size()), 1'(m_q.size() < DEPTH)}) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL rand_cycle_%0d: got v=%0b pc=%h inst=%h cnt=%0d rdy=%0b want %0b/%h/%h/%0d",
                             i, id_valid, id_pc, id_inst, count, if_ready, m_valid, m_pc, m_inst, m_q.size());
            end
        end
        if_valid = 1'b0;
        id_stall = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle();
            if (id_valid) got.push_back(id_pc);
        end
        n_cmp++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL rand_model: got %0d mismatching cycles want 0", errs);
        end
        n_cmp++;
        if (got != sent) begin
            n_err++;
            $display("FAIL rand_order: got %0d pcs out want %0d in same order", got.size(), sent.size());
        end
    endtask

    task automatic test_flush();
        id_stall = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h30;
        if_inst  = 32'hB0;
        cycle();
        id_stall = 1'b1;
        for (int i = 1; i < 4; i++) begin
            if_pc   = 32'h30 + 32'(4 * i);
            if_inst = 32'hB0 + 32'(i);
            cycle();
        end
        n_cmp++;
        if ({count, id_valid} !== {3'd3, 1'b1}) begin
            n_err++;
            $display("FAIL flush_setup: got cnt=%0d v=%0b want 3/1", count, id_valid);
        end
        flush   = 1'b1;
        if_pc   = 32'h40;
        if_inst = 32'hC0;
        cycle();
        flush = 1'b0;
        n_cmp++;
        if ({count, id_valid, id_pc} !== {3'd0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL flush_clear: got cnt=%0d v=%0b pc=%h want 0/0/0", count, id_valid, id_pc);
        end
        if_valid = 1'b0;
        id_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if (id_valid !== 1'b0 || id_pc === 32'h40) begin
                n_err++;
                $display("FAIL flush_after_%0d: got v=%0b pc=%h want 0 and not 00000040", i, id_valid, id_pc);
            end
        end
    endtask

    task automatic test_async_reset();
        id_stall = 1'b0;
        if_valid = 1'b1;
        if_pc    = 32'h50;
        if_inst  = 32'hD0;
        cycle();
        id_stall = 1'b1;
        for (int i = 1; i < 3; i++) begin
            if_pc   = 32'h50 + 32'(4 * i);
            if_inst = 32'hD0 + 32'(i);
            cycle();
        end
        if_valid = 1'b0;
        n_cmp++;
        if ({count, id_valid} !== {3'd2, 1'b1}) begin
            n_err++;
            $display("FAIL areset_setup: got cnt=%0d v=%0b want 2/1", count, id_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({id_valid, id_pc, id_inst, count, if_ready} !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL areset_now: got v=%0b pc=%h inst=%h cnt=%0d rdy=%0b want 0/0/0/0/1",
                     id_valid, id_pc, id_inst, count, if_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        id_stall = 1'b0;
        test_bypass("areset_bypass");
    endtask

    initial begin
        test_reset();
        test_bypass("bypass");
        test_stall_fill();
        test_random_wrap();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised successor to the IF/ID pipeline register. It places a DEPTH-entry in-order instruction queue between fetch and decode, so fetch can keep running while decode stalls. The block has a registered decode-facing output stage, a zero-latency bypass when the queue is empty, bubble insertion, and a flush that discards everything. It sits between the fetch stage and the decode stage.

Parameters:
ADDR_W, 32, PC width (matches InstAddrBus)
INST_W, 32, instruction width (matches InstBus)
DEPTH, 4, storage entries; power of 2, >= 2
PTR_W, $clog2(DEPTH), derived localparam; not overridable

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  branch/exception flush; discard all contents
if_valid  in  1  fetch presents a pc/inst pair this cycle
if_pc  in  ADDR_W  fetched PC
if_inst  in  INST_W  fetched instruction
if_ready  out  1  queue can accept; equals (count < DEPTH)
id_stall  in  1  decode stage stalled; output stage must hold
id_valid  out  1  id_pc/id_inst carry a real instruction
id_pc  out  ADDR_W  PC to decode
id_inst  out  INST_W  instruction to decode
count  out  PTR_W+1  entries in storage, excluding the output stage

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, id_valid=0, id_pc=ZeroWord, id_inst=ZeroWord, if_ready=1. Storage contents are don't-care.
- All state updates on the rising clk edge. Priority order is: reset, then flush, then normal operation.
- Flush edge: count=0, both pointers=0, id_valid=0, id_pc/id_inst=0. An if_valid in the same cycle is dropped. id_stall is ignored.
- Accept condition: push_req = if_valid & if_ready.
- if_ready depends only on the registered count. A same-cycle pop never frees a slot for a same-cycle push.
- Output stage update when id_stall=0:
  - count>0: pop the head (rd_ptr) into id_*, set id_valid=1, rd_ptr+1.
  - count==0 and push_req: bypass if_pc/if_inst straight into id_*, set id_valid=1. No storage write, count unchanged. Latency is one edge, identical to the legacy IF/ID register.
  - count==0 and no push: insert a bubble (id_valid=0, id_pc=0, id_inst=0, the NOP).
- Output stage when id_stall=1: id_* and id_valid hold.
- Storage write: on push_req not consumed by bypass, write at wr_ptr, then wr_ptr+1.
- Pointers wrap modulo DEPTH.
- count update: +1 on write only, -1 on pop only, unchanged on both or neither. count never exceeds DEPTH and never underflows.
- Order is strictly FIFO. Bypass can occur only when storage is empty, so it never reorders.
- Full (count==DEPTH): if_ready=0. if_valid is ignored and fetch must hold its pc/inst.
- Reset mid-operation: all contents are lost immediately, with no clock needed.

Decomposition:
- Shared defines supply InstAddrBus, InstBus, ZeroWord and the NOP encoding (0). No new global constants.
- One natural sub-module, inst_fifo. It holds the DEPTH x (ADDR_W+INST_W) storage, pointers and count, with ports push/pop/clear/full/empty and head data.
- if_id_queue keeps the output stage, bypass mux and bubble logic.

Test Plan:
1. Reset, then idle with if_valid=0 -> id_valid=0, id_inst=0x00000000, count=0, if_ready=1 every cycle.
2. Bypass: empty queue, id_stall=0, push pc=0x00010000, inst=0x00000080 at edge k -> after edge k, id_pc=0x00010000, id_inst=0x00000080, id_valid=1, count=0.
3. Stall-fill: hold id_stall=1 and push pc 0x10, 0x14, 0x18, 0x1C, 0x20 (DEPTH=4).
   - Expected: count reaches 4, if_ready=0, the 0x20 push is ignored while not accepted, id_* holds its prior value.
   - Release the stall with no further pushes -> id_pc shows 0x10, 0x14, 0x18, 0x1C on successive edges, then a bubble, with count 3,2,1,0.
4. Wrap: run 10 push/pop pairs with intermittent id_stall -> output PC sequence exactly equals input sequence, and pointers wrap without loss.
5. Flush with count=3, id_valid=1 and a simultaneous push of pc=0x40 -> next edge count=0, id_valid=0, id_pc=0. 0x40 never appears.
6. Async reset: assert rst=0 between clock edges with count=2 -> outputs go to reset values before the next edge. After release, scenario 2 passes.
